play_timer_bcd: RTL and testbench

Parametrised successor to the MM:SS play-time counter. It keeps a 4-digit BCD minutes:seconds timer with digit limits 9/5/9/5 and an internal 1 Hz prescaler. It adds up/down (countdown) mode, preset load, pause/resume via gaming, a terminal "expired" flag and an explicit state machine. It sits between the game controller (gaming, score_zero) and the 7-segment display mux, which consumes digit3..digit0.

---
 rtl/play_timer_bcd_pkg.sv | 21 ++
 rtl/play_timer_bcd_if.sv | 36 +++
 rtl/play_timer_bcd_digit.sv | 37 +++
 rtl/play_timer_bcd.sv | 169 ++++++++++++++++
 tb/tb_play_timer_bcd.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/play_timer_bcd_pkg.sv
// Shared types and constants for the MM:SS BCD play timer.
// State encoding, digit type, digit limits and the preset clamp helper.
package play_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t LIM_ONES = 4'd9;
    localparam bcd_t LIM_TENS = 4'd5;

    function automatic bcd_t clamp(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/play_timer_bcd_if.sv
// Controller/display-side bundle of the play timer.
// master = game controller + display mux, slave = timer.
interface play_timer_bcd_if;
    import play_timer_pkg::*;

    logic       clr;
    logic       load;
    logic [7:0] preset_mm;
    logic [7:0] preset_ss;
    logic       mode_down;
    logic       start;
    logic       gaming;
    logic       score_zero;
    bcd_t       digit3;
    bcd_t       digit2;
    bcd_t       digit1;
    bcd_t       digit0;
    logic       running;
    logic       expired;
    logic       tick;

    modport master (
        output clr, load, preset_mm, preset_ss,
        output mode_down, start, gaming, score_zero,
        input  digit3, digit2, digit1, digit0,
        input  running, expired, tick
    );

    modport slave (
        input  clr, load, preset_mm, preset_ss,
        input  mode_down, start, gaming, score_zero,
        output digit3, digit2, digit1, digit0,
        output running, expired, tick
    );

endinterface

// File: rtl/play_timer_bcd_digit.sv
// One BCD digit counting up or down between 0 and a limit.
// carry/borrow are combinational so a step ripples within one cycle.
module bcd_digit_updown
    import play_timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic dir,
    input  bcd_t limit,
    input  logic load,
    input  bcd_t load_val,
    input  logic clr,
    output bcd_t value,
    output logic carry_out,
    output logic borrow_out
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            if (dir)
                value <= (value == 4'd0) ? limit : value - 4'd1;
            else
                value <= (value == limit) ? 4'd0 : value + 4'd1;
        end
    end

    assign carry_out  = en && !dir && (value == limit);
    assign borrow_out = en && dir && (value == 4'd0);

endmodule

// File: rtl/play_timer_bcd.sv
// MM:SS BCD play timer: up/down count, preset load, pause, expiry.
// Holds the FSM and 1 Hz prescaler; digits live in a ripple chain.
module play_timer_bcd
    import play_timer_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter bit SAT_AT_MAX = 1'b1
) (
    input logic             clk,
    input logic             rst,
    play_timer_bcd_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
    localparam bcd_t LIM [4] = '{LIM_ONES, LIM_TENS, LIM_ONES, LIM_TENS};

    state_t        state, state_n;
    logic [PW-1:0] psc, psc_n;
    logic          dir, dir_n;
    logic          tick_q, tick_n;
    logic          exp_q, exp_n;
    logic          run_q;
    logic          step_en;
    logic          load_en;
    bcd_t          dig [4];
    bcd_t          pre [4];
    logic [3:0]    en;
    logic [3:0]    cy;
    logic [3:0]    bw;
    logic          unused_chain;

    assign pre[0] = clamp(bus.preset_ss[3:0], LIM_ONES);
    assign pre[1] = clamp(bus.preset_ss[7:4], LIM_TENS);
    assign pre[2] = clamp(bus.preset_mm[3:0], LIM_ONES);
    assign pre[3] = clamp(bus.preset_mm[7:4], LIM_TENS);

    assign en[0] = step_en;
    assign en[1] = cy[0] | bw[0];
    assign en[2] = cy[1] | bw[1];
    assign en[3] = cy[2] | bw[2];
    assign unused_chain = cy[3] ^ bw[3];

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_updown u_dig (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .dir       (dir),
            .limit     (LIM[i]),
            .load      (load_en),
            .load_val  (pre[i]),
            .clr       (bus.clr),
            .value     (dig[i]),
            .carry_out (cy[i]),
            .borrow_out(bw[i])
        );
    end

    logic at_max;
    logic to_zero;
    logic is_zero;
    logic pre_zero;
    logic start_zero;

    assign at_max = (dig[3] == LIM_TENS) && (dig[2] == LIM_ONES)
                 && (dig[1] == LIM_TENS) && (dig[0] == LIM_ONES);
    assign is_zero = (dig[3] == 4'd0) && (dig[2] == 4'd0)
                  && (dig[1] == 4'd0) && (dig[0] == 4'd0);
    assign to_zero = (dig[3] == 4'd0) && (dig[2] == 4'd0)
                  && (dig[1] == 4'd0) && (dig[0] == 4'd1);
    assign pre_zero = (pre[3] == 4'd0) && (pre[2] == 4'd0)
                   && (pre[1] == 4'd0) && (pre[0] == 4'd0);
    // A same-cycle load decides what the countdown starts from.
    assign start_zero = bus.load ? pre_zero : is_zero;

    always_comb begin
        state_n = state;
        psc_n   = psc;
        dir_n   = dir;
        tick_n  = 1'b0;
        exp_n   = exp_q;
        step_en = 1'b0;
        load_en = 1'b0;
        unique case (state)
            IDLE: begin
                load_en = bus.load;
                if (bus.start) begin
                    psc_n = '0;
                    dir_n = bus.mode_down;
                    if (bus.mode_down && start_zero) begin
                        state_n = DONE;
                        exp_n   = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.score_zero) begin
                    state_n = DONE;
                end else if (psc == PSC_MAX) begin
                    psc_n = '0;
                    if (!dir && at_max && SAT_AT_MAX) begin
                        state_n = DONE;
                        exp_n   = 1'b1;
                    end else begin
                        step_en = 1'b1;
                        tick_n  = 1'b1;
                        if (dir && to_zero) begin
                            state_n = DONE;
                            exp_n   = 1'b1;
                        end else if (!bus.gaming) begin
                            state_n = PAUSED;
                        end
                    end
                end else if (!bus.gaming) begin
                    state_n = PAUSED;
                end else begin
                    psc_n = psc + PW'(1);
                end
            end
            PAUSED: begin
                if (bus.score_zero)
                    state_n = DONE;
                else if (bus.gaming)
                    state_n = RUN;
            end
            DONE: begin
            end
            default: state_n = IDLE;
        endcase
        if (bus.clr) begin
            state_n = IDLE;
            psc_n   = '0;
            exp_n   = 1'b0;
            tick_n  = 1'b0;
            step_en = 1'b0;
            load_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            psc    <= '0;
            dir    <= 1'b0;
            tick_q <= 1'b0;
            exp_q  <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            state  <= state_n;
            psc    <= psc_n;
            dir    <= dir_n;
            tick_q <= tick_n;
            exp_q  <= exp_n;
            run_q  <= (state_n == RUN);
        end
    end

    assign bus.digit0  = dig[0];
    assign bus.digit1  = dig[1];
    assign bus.digit2  = dig[2];
    assign bus.digit3  = dig[3];
    assign bus.running = run_q;
    assign bus.expired = exp_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_play_timer_bcd.sv
// Directed bench for play_timer_bcd at TICK_DIV=4.
// A second instance with SAT_AT_MAX=0 covers the 59:59 wrap.
module tb_play_timer_bcd;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    play_timer_bcd_if bus ();
    play_timer_bcd_if bw ();

    play_timer_bcd #(.TICK_DIV(4), .SAT_AT_MAX(1'b1)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    play_timer_bcd #(.TICK_DIV(4), .SAT_AT_MAX(1'b0)) u_wrap (
        .clk(clk),
        .rst(rst),
        .bus(bw)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] d();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic init_inputs();
        bus.clr = 0; bus.load = 0; bus.preset_mm = 0; bus.preset_ss = 0;
        bus.mode_down = 0; bus.start = 0; bus.gaming = 1; bus.score_zero = 0;
        bw.clr = 0; bw.load = 0; bw.preset_mm = 0; bw.preset_ss = 0;
        bw.mode_down = 0; bw.start = 0; bw.gaming = 1; bw.score_zero = 0;
    endtask

    task automatic do_clr();
        bus.clr = 1;
        cyc(1);
        bus.clr = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        cyc(1);
        rst = 1;
        checks++;
        if (d() !== 16'h0000) begin
            errors++; $display("FAIL reset_digits got=%h exp=0000", d());
        end
        checks++;
        if ({bus.running, bus.expired, bus.tick} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000",
                     {bus.running, bus.expired, bus.tick});
        end
    endtask

    task automatic test_count_up();
        bus.mode_down = 0;
        bus.start = 1;
        cyc(1);
        bus.start = 0;
        checks++;
        if (bus.running !== 1'b1) begin
            errors++; $display("FAIL up_running got=%b exp=1", bus.running);
        end
        for (int i = 0; i < 60; i++) begin
            cyc(3);
            checks++;
            if (bus.tick !== 1'b0) begin
                errors++; $display("FAIL up_notick i=%0d got=%b exp=0", i, bus.tick);
            end
            cyc(1);
            checks++;
            if (bus.tick !== 1'b1) begin
                errors++; $display("FAIL up_tick i=%0d got=%b exp=1", i, bus.tick);
            end
            if (i == 9) begin
                checks++;
                if (d() !== 16'h0010) begin
                    errors++; $display("FAIL up_10s got=%h exp=0010", d());
                end
            end
        end
        checks++;
        if (d() !== 16'h0100) begin
            errors++; $display("FAIL up_60s got=%h exp=0100", d());
        end
        do_clr();
        checks++;
        if ({d(), bus.running} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL up_clr got=%h/%b exp=0000/0", d(), bus.running);
        end
    endtask

    task automatic test_sat_up();
        bus.preset_mm = 8'h59; bus.preset_ss = 8'h58;
        bus.mode_down = 0; bus.load = 1; bus.start = 1;
        cyc(1);
        bus.load = 0; bus.start = 0;
        checks++;
        if ({d(), bus.running} !== {16'h5958, 1'b1}) begin
            errors++;
            $display("FAIL sat_load got=%h/%b exp=5958/1", d(), bus.running);
        end
        cyc(4);
        checks++;
        if ({d(), bus.tick} !== {16'h5959, 1'b1}) begin
            errors++; $display("FAIL sat_step got=%h/%b exp=5959/1", d(), bus.tick);
        end
        cyc(3);
        checks++;
        if (bus.expired !== 1'b0) begin
            errors++; $display("FAIL sat_early got=%b exp=0", bus.expired);
        end
        cyc(1);
        checks++;
        if ({d(), bus.expired, bus.tick, bus.running} !== {16'h5959, 3'b100}) begin
            errors++;
            $display("FAIL sat_done got=%h/%b%b%b exp=5959/100",
                     d(), bus.expired, bus.tick, bus.running);
        end
        bus.start = 1; bus.load = 1; bus.preset_ss = 8'h00;
        cyc(1);
        bus.start = 0; bus.load = 0;
        cyc(4);
        checks++;
        if ({d(), bus.running, bus.expired} !== {16'h5959, 2'b01}) begin
            errors++;
            $display("FAIL sat_hold got=%h/%b%b exp=5959/01",
                     d(), bus.running, bus.expired);
        end
        do_clr();
        checks++;
        if ({d(), bus.expired} !== {16'h0000, 1'b0}) begin
            errors++; $display("FAIL sat_clr got=%h/%b exp=0000/0", d(), bus.expired);
        end
    endtask

    task automatic test_count_down();
        bus.preset_mm = 8'h00; bus.preset_ss = 8'h03;
        bus.mode_down = 1; bus.load = 1; bus.start = 1;
        cyc(1);
        bus.load = 0; bus.start = 0; bus.mode_down = 0;
        cyc(4);
        checks++;
        if ({d(), bus.tick} !== {16'h0002, 1'b1}) begin
            errors++; $display("FAIL dn_2 got=%h/%b exp=0002/1", d(), bus.tick);
        end
        cyc(4);
        checks++;
        if ({d(), bus.expired} !== {16'h0001, 1'b0}) begin
            errors++; $display("FAIL dn_1 got=%h/%b exp=0001/0", d(), bus.expired);
        end
        cyc(4);
        checks++;
        if ({d(), bus.expired, bus.running, bus.tick} !== {16'h0000, 3'b101}) begin
            errors++;
            $display("FAIL dn_0 got=%h/%b%b%b exp=0000/101",
                     d(), bus.expired, bus.running, bus.tick);
        end
        cyc(1);
        checks++;
        if ({bus.tick, bus.expired} !== 2'b01) begin
            errors++;
            $display("FAIL dn_after got=%b%b exp=01", bus.tick, bus.expired);
        end
        do_clr();
        bus.preset_mm = 8'h10; bus.preset_ss = 8'h00;
        bus.mode_down = 1; bus.load = 1; bus.start = 1;
        cyc(1);
        bus.load = 0; bus.start = 0;
        cyc(4);
        checks++;
        if ({d(), bus.tick} !== {16'h0959, 1'b1}) begin
            errors++; $display("FAIL dn_borrow got=%h/%b exp=0959/1", d(), bus.tick);
        end
        do_clr();
        bus.start = 1;
        cyc(1);
        bus.start = 0; bus.mode_down = 0;
        checks++;
        if ({bus.expired, bus.running, bus.tick} !== 3'b100) begin
            errors++;
            $display("FAIL dn_zero_start got=%b%b%b exp=100",
                     bus.expired, bus.running, bus.tick);
        end
        do_clr();
    endtask

    task automatic test_pause();
        bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(2);
        bus.gaming = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            checks++;
            if (bus.tick !== 1'b0) begin
                errors++; $display("FAIL pause_tick i=%0d got=%b exp=0", i, bus.tick);
            end
        end
        checks++;
        if ({d(), bus.running} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL pause_hold got=%h/%b exp=0000/0", d(), bus.running);
        end
        bus.gaming = 1;
        cyc(1);
        checks++;
        if ({bus.running, bus.tick} !== 2'b10) begin
            errors++;
            $display("FAIL resume_1 got=%b%b exp=10", bus.running, bus.tick);
        end
        cyc(1);
        checks++;
        if (bus.tick !== 1'b0) begin
            errors++; $display("FAIL resume_2 got=%b exp=0", bus.tick);
        end
        cyc(1);
        checks++;
        if ({d(), bus.tick} !== {16'h0001, 1'b1}) begin
            errors++; $display("FAIL resume_tick got=%h/%b exp=0001/1", d(), bus.tick);
        end
        do_clr();
    endtask

    task automatic test_score_zero();
        bus.preset_mm = 8'h00; bus.preset_ss = 8'h07;
        bus.load = 1; bus.start = 1;
        cyc(1);
        bus.load = 0; bus.start = 0;
        cyc(2);
        bus.score_zero = 1;
        cyc(1);
        bus.score_zero = 0;
        checks++;
        if ({d(), bus.running, bus.expired} !== {16'h0007, 2'b00}) begin
            errors++;
            $display("FAIL sz_done got=%h/%b%b exp=0007/00",
                     d(), bus.running, bus.expired);
        end
        cyc(8);
        checks++;
        if ({d(), bus.tick, bus.expired} !== {16'h0007, 2'b00}) begin
            errors++;
            $display("FAIL sz_frozen got=%h/%b%b exp=0007/00",
                     d(), bus.tick, bus.expired);
        end
        do_clr();
        bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(5);
        checks++;
        if ({d(), bus.running} !== {16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL midrun got=%h/%b exp=0001/1", d(), bus.running);
        end
        rst = 0;
        cyc(1);
        rst = 1;
        checks++;
        if ({d(), bus.running, bus.expired, bus.tick} !== {16'h0000, 3'b000}) begin
            errors++;
            $display("FAIL midrun_rst got=%h/%b%b%b exp=0000/000",
                     d(), bus.running, bus.expired, bus.tick);
        end
    endtask

    task automatic test_clamp();
        bus.preset_mm = 8'h7C; bus.preset_ss = 8'hFA;
        bus.load = 1;
        cyc(1);
        bus.load = 0;
        checks++;
        if ({d(), bus.running} !== {16'h5959, 1'b0}) begin
            errors++;
            $display("FAIL clamp got=%h/%b exp=5959/0", d(), bus.running);
        end
        do_clr();
        bus.start = 1;
        cyc(1);
        bus.start = 0;
        bus.preset_mm = 8'h12; bus.preset_ss = 8'h34;
        bus.load = 1;
        cyc(1);
        bus.load = 0;
        checks++;
        if ({d(), bus.running} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL run_load got=%h/%b exp=0000/1", d(), bus.running);
        end
        do_clr();
    endtask

    task automatic test_wrap();
        bw.preset_mm = 8'h59; bw.preset_ss = 8'h59;
        bw.load = 1; bw.start = 1;
        cyc(1);
        bw.load = 0; bw.start = 0;
        cyc(3);
        checks++;
        if (bw.tick !== 1'b0) begin
            errors++; $display("FAIL wrap_early got=%b exp=0", bw.tick);
        end
        cyc(1);
        checks++;
        if ({bw.digit3, bw.digit2, bw.digit1, bw.digit0,
             bw.tick, bw.running, bw.expired} !== {16'h0000, 3'b110}) begin
            errors++;
            $display("FAIL wrap got=%h%h%h%h/%b%b%b exp=0000/110",
                     bw.digit3, bw.digit2, bw.digit1, bw.digit0,
                     bw.tick, bw.running, bw.expired);
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_count_up();
        test_sat_up();
        test_count_down();
        test_pause();
        test_score_zero();
        test_clamp();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
